// File: rtl/tlp_thruput_meter.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tlp_thruput_meter
//
// Purpose:
//   Measures TX TLP throughput over a fixed window of WINDOW_CYC clk_125 cycles.
//   It taps the PCIe core TX handshake in parallel with the TLP generator. It
//   counts accepted beats and start-of-packet beats, then latches the totals for
//   the LED/display and debug readout logic.
//
// Parameters:
//   WINDOW_CYC : number of counted cycles per window (>= 2)
//   CNT_W      : width of accumulators and result registers
//
// Ports:
//   clk_125     in   PCIe core user clock; all logic runs on the rising edge
//   rst         in   synchronous reset, active-high
//   start       in   1-cycle pulse; begins a window (ignored unless idle)
//   abort       in   1-cycle pulse; cancels a running window, no result update
//   cont        in   sampled in LATCH; 1 = immediately start another window
//   tx_beat     in   TX data beat accepted this cycle
//   tx_sop      in   qualifies tx_beat as the first beat of a TLP
//   rx_beat     in   RX data beat accepted this cycle      (RX_COUNT_EN only)
//   rx_beat_cnt out  RX beats in the last completed window (RX_COUNT_EN only)
//   busy        out  high while a window is running (MEAS and LATCH)
//   done        out  1-cycle pulse; results are valid in the same cycle
//   beat_cnt    out  TX beats in the last completed window
//   tlp_cnt     out  TLPs (sop beats) in the last completed window
//   sat         out  a counter saturated during the last completed window
//
// Configuration:
//   `define RX_COUNT_EN adds a third channel that counts rx_beat. It uses the
//   same window, saturation rules and latch timing as the TX channels.
// -----------------------------------------------------------------------------
module tlp_thruput_meter #(
    parameter int unsigned WINDOW_CYC = 125000000,
    parameter int unsigned CNT_W      = 32
) (
    input  logic             clk_125,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic             cont,
    input  logic             tx_beat,
    input  logic             tx_sop,
`ifdef RX_COUNT_EN
    input  logic             rx_beat,
    output logic [CNT_W-1:0] rx_beat_cnt,
`endif
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] beat_cnt,
    output logic [CNT_W-1:0] tlp_cnt,
    output logic             sat
);

    // Counting channels: 0 = TX beats, 1 = TX TLPs, 2 = RX beats (optional).
`ifdef RX_COUNT_EN
    localparam int unsigned NCH = 3;
`else
    localparam int unsigned NCH = 2;
`endif

    localparam int unsigned     TMR_W    = (WINDOW_CYC > 1) ? $clog2(WINDOW_CYC) : 1;
    localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(WINDOW_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_MEAS  = 2'd1,
        ST_LATCH = 2'd2
    } state_t;

    state_t                      state_q;
    logic [TMR_W-1:0]            timer_q;
    logic [NCH-1:0][CNT_W-1:0]   acc_q;
    logic [NCH-1:0][CNT_W-1:0]   acc_d;
    logic [NCH-1:0][CNT_W-1:0]   res_q;
    logic                        sat_acc_q;
    logic                        sat_acc_d;
    logic                        sat_q;
    logic                        busy_q;
    logic                        done_q;
    logic [NCH-1:0]              inc;
    logic [NCH-1:0]              ovf;

    assign inc[0] = tx_beat;
    assign inc[1] = tx_beat & tx_sop;   // sop without a beat is ignored
`ifdef RX_COUNT_EN
    assign inc[2] = rx_beat;
`endif

    // Per-channel saturating increment. An increment requested while the
    // accumulator is already all-ones is dropped and flagged as saturation.
    generate
        for (genvar gi = 0; gi < NCH; gi++) begin : g_chan
            assign ovf[gi]   = inc[gi] && (acc_q[gi] == CNT_MAX);
            assign acc_d[gi] = (inc[gi] && !ovf[gi]) ? acc_q[gi] + CNT_W'(1) : acc_q[gi];
        end
    endgenerate

    assign sat_acc_d = sat_acc_q | (|ovf);

    // The FSM and all outputs are registered together. The last MEAS cycle
    // latches acc_d directly so that this cycle's beats are included. Results
    // and the done pulse therefore become visible together during LATCH.
    always_ff @(posedge clk_125) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            timer_q   <= '0;
            acc_q     <= '0;
            res_q     <= '0;
            sat_acc_q <= 1'b0;
            sat_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_q   <= ST_MEAS;
                        timer_q   <= TMR_LOAD;
                        acc_q     <= '0;
                        sat_acc_q <= 1'b0;
                        busy_q    <= 1'b1;
                    end
                end
                ST_MEAS: begin
                    if (abort) begin
                        // Abort takes priority, even on the final cycle.
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        acc_q     <= acc_d;
                        sat_acc_q <= sat_acc_d;
                        if (timer_q == '0) begin
                            state_q <= ST_LATCH;
                            res_q   <= acc_d;
                            sat_q   <= sat_acc_d;
                            done_q  <= 1'b1;
                        end else begin
                            timer_q <= timer_q - TMR_W'(1);
                        end
                    end
                end
                ST_LATCH: begin
                    // Beats in this cycle are deliberately not counted.
                    if (cont) begin
                        state_q   <= ST_MEAS;
                        timer_q   <= TMR_LOAD;
                        acc_q     <= '0;
                        sat_acc_q <= 1'b0;
                    end else begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign beat_cnt = res_q[0];
    assign tlp_cnt  = res_q[1];
    assign sat      = sat_q;
`ifdef RX_COUNT_EN
    assign rx_beat_cnt = res_q[2];
`endif

endmodule
